// File: rtl/uart_tx_scheduler_if.sv
// Requester handshake plus transmitter drive signals for uart_tx_scheduler.
// The master side is the requesters and the transmitter; the slave side is the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_start;
  logic                 o_tx_reset;
  logic                 o_busy;
  logic [ID_W-1:0]      o_grant_id;

  modport master (
    output i_req_valid, i_req_data,
    input  o_req_ready, o_tx_data, o_tx_start, o_tx_reset, o_busy, o_grant_id
  );

  modport slave (
    input  i_req_valid, i_req_data,
    output o_req_ready, o_tx_data, o_tx_start, o_tx_reset, o_busy, o_grant_id
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// The transmitter reports no completion, so each frame is timed here with a guard counter.
//
// state | meaning
// IDLE  | searching requesters; a valid one is accepted this cycle
// START | single-cycle start pulse to the transmitter, guard counter loaded
// WAIT  | frame in flight (or post-reset drain); counts down to 0
module uart_tx_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int BAUD_RATE       = 10000,
  parameter int CLOCK_FREQUENCY = 250000
) (
  input logic              clk,
  input logic              r_reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int FRAME_CYCLES      = 10 * CYCLES_PER_SAMPLE + 2;
  localparam int ID_W              = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t          state;
  logic [15:0]     cnt;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            grant;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            busy;
  logic [ID_W-1:0] grant_id;
  int              idx;

  // Search starts just after the last winner, so the last winner has lowest priority.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && bus.i_req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign grant           = found && (state == IDLE) && !r_reset;
  assign bus.o_req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  assign bus.o_tx_reset  = r_reset;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_tx_start  = tx_start;
  assign bus.o_busy      = busy;
  assign bus.o_grant_id  = grant_id;

  // Reset parks in WAIT with a full count so a frame already in the transmitter drains.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      state    <= WAIT;
      cnt      <= 16'(FRAME_CYCLES - 1);
      last     <= ID_W'(NUM_REQ - 1);
      grant_id <= ID_W'(NUM_REQ - 1);
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data  <= bus.i_req_data[{winner, 3'b000} +: 8];
            last     <= winner;
            grant_id <= winner;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start <= 1'b0;
          cnt      <= 16'(FRAME_CYCLES - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == 16'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
